// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32 M-extension multiply/divide unit:
// funct3 op codes, FSM state encoding and operand signedness decode.
package mdu_pkg;

    localparam logic [6:0] MDU_FUNCT7 = 7'b0000001;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } mdu_state_t;

    function automatic logic op_signed_a(input logic [2:0] f3);
        return (f3 == MDU_MULH) || (f3 == MDU_MULHSU) || (f3 == MDU_DIV) || (f3 == MDU_REM);
    endfunction

    function automatic logic op_signed_b(input logic [2:0] f3);
        return (f3 == MDU_MULH) || (f3 == MDU_DIV) || (f3 == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Start/done request bus between the EX stage (master) and the multiply/divide unit (slave).
interface mdu_iter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             start;
    logic             flush;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             done;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output start, flush, funct3, op_a, op_b, tag_in,
        input  busy, done, result, tag_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, tag_in,
        output busy, done, result, tag_out
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32 M-extension unit: XLEN-cycle shift-add multiply / restoring divide on
// operand magnitudes, followed by a one-cycle sign fixup and a single-cycle done pulse.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    mdu_iter_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       f3_q;
    logic             sa_q, sb_q;
    logic [TAG_W-1:0] tag_q;
    logic [XLEN-1:0]  mag_b_q;
    logic [XLEN-1:0]  hi_q, lo_q;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;

    logic             accept_c, special_c, sa_c, sb_c;
    logic [XLEN-1:0]  mag_a_c, mag_b_c, special_res_c;
    logic [XLEN:0]    mul_sum_c, div_sh_c;
    logic             div_ge_c;
    logic [XLEN-1:0]  div_sub_c, hi_n, lo_n;
    logic [2*XLEN-1:0] prod_fix_c;
    logic [XLEN-1:0]  quo_fix_c, rem_fix_c, final_c;

    // Accept decode, operand magnitudes and the divide special cases that bypass CALC
    always_comb begin
        accept_c = (state_q == ST_IDLE) && bus.start && !bus.flush;
        sa_c     = op_signed_a(bus.funct3) && bus.op_a[XLEN-1];
        sb_c     = op_signed_b(bus.funct3) && bus.op_b[XLEN-1];
        mag_a_c  = sa_c ? -bus.op_a : bus.op_a;
        mag_b_c  = sb_c ? -bus.op_b : bus.op_b;
        special_c     = 1'b0;
        special_res_c = '0;
        if (bus.funct3[2]) begin
            if (bus.op_b == '0) begin
                special_c     = 1'b1;
                special_res_c = bus.funct3[1] ? bus.op_a : '1;
            end else if ((bus.funct3 == MDU_DIV || bus.funct3 == MDU_REM) &&
                         bus.op_a == MOST_NEG && bus.op_b == '1) begin
                special_c     = 1'b1;
                special_res_c = bus.funct3[1] ? '0 : bus.op_a;
            end
        end
    end

    // One radix-2 step: hi:lo is the product accumulator or remainder:dividend/quotient
    always_comb begin
        mul_sum_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
        div_sh_c  = {hi_q, lo_q[XLEN-1]};
        div_ge_c  = div_sh_c >= {1'b0, mag_b_q};
        div_sub_c = div_sh_c[XLEN-1:0] - mag_b_q;
        if (f3_q[2]) begin
            hi_n = div_ge_c ? div_sub_c : div_sh_c[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], div_ge_c};
        end else begin
            hi_n = mul_sum_c[XLEN:1];
            lo_n = {mul_sum_c[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign restoration and final result selection
    always_comb begin
        prod_fix_c = (sa_q ^ sb_q) ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_fix_c  = (sa_q ^ sb_q) ? -lo_q : lo_q;
        rem_fix_c  = sa_q ? -hi_q : hi_q;
        if (f3_q[2])
            final_c = f3_q[1] ? rem_fix_c : quo_fix_c;
        else if (f3_q == MDU_MUL)
            final_c = prod_fix_c[XLEN-1:0];
        else
            final_c = prod_fix_c[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept_c) state_d = special_c ? ST_DONE : ST_CALC;
            ST_CALC:  if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIXUP;
            ST_FIXUP: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    // Next values for the registered outputs; flush leaves result/tag_out untouched
    always_comb begin
        busy_d    = (state_d == ST_CALC) || (state_d == ST_FIXUP);
        done_d    = (state_d == ST_DONE);
        res_d     = res_q;
        tag_out_d = tag_out_q;
        if (accept_c && special_c) begin
            res_d     = special_res_c;
            tag_out_d = bus.tag_in;
        end else if (state_q == ST_FIXUP && !bus.flush) begin
            res_d     = final_c;
            tag_out_d = tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
            tag_out_q <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_q     <= res_d;
            tag_out_q <= tag_out_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            f3_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            tag_q   <= '0;
            mag_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (accept_c) begin
            cnt_q   <= '0;
            f3_q    <= bus.funct3;
            sa_q    <= sa_c;
            sb_q    <= sb_c;
            tag_q   <= bus.tag_in;
            mag_b_q <= mag_b_c;
            hi_q    <= '0;
            lo_q    <= mag_a_c;
        end else if (state_q == ST_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = res_q;
    assign bus.tag_out = tag_out_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: cycle-level behavioural model plus directed vectors,
// with a second XLEN=8 instance for the narrow-width cases.
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mdu_iter_if #(.XLEN(32), .TAG_W(5)) bus ();
    mdu_iter_if #(.XLEN(8),  .TAG_W(5)) bus8 ();

    mdu_iter #(.XLEN(32), .TAG_W(5)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mdu_iter #(.XLEN(8),  .TAG_W(5)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference result straight from the RV32 M definitions
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] sa64, sb64, ua64, ub64, p;
        int si, sj;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        si = a;
        sj = b;
        p  = '0;
        case (f3)
            MDU_MUL:    begin p = ua64 * ub64; return p[31:0];  end
            MDU_MULH:   begin p = sa64 * sb64; return p[63:32]; end
            MDU_MULHSU: begin p = sa64 * ub64; return p[63:32]; end
            MDU_MULHU:  begin p = ua64 * ub64; return p[63:32]; end
            MDU_DIV:    if (b == 0) return 32'hFFFF_FFFF;
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                        else return 32'(si / sj);
            MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MDU_REM:    if (b == 0) return a;
                        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                        else return 32'(si % sj);
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if ((f3 == MDU_DIV || f3 == MDU_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Model state: what the 32-bit DUT outputs must show in each cycle
    logic        pend_valid = 1'b0;
    int          acc_cyc = 0, done_cyc = 0, idle_from = 0;
    logic [31:0] pend_res = '0, res_now = '0;
    logic [4:0]  pend_tag = '0, tag_now = '0;

    always @(negedge clk) begin
        logic exp_busy, exp_done;
        if (rst) begin
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_done", 64'(bus.done), 64'd0);
            check("rst_result", 64'(bus.result), 64'd0);
            check("rst_tag", 64'(bus.tag_out), 64'd0);
            pend_valid = 1'b0;
            res_now    = '0;
            tag_now    = '0;
            idle_from  = 0;
        end else begin
            exp_done = 1'b0;
            if (pend_valid && cyc == done_cyc) begin
                exp_done   = 1'b1;
                res_now    = pend_res;
                tag_now    = pend_tag;
                pend_valid = 1'b0;
            end
            exp_busy = pend_valid && cyc > acc_cyc;
            check("busy", 64'(bus.busy), 64'(exp_busy));
            check("done", 64'(bus.done), 64'(exp_done));
            check("result", 64'(bus.result), 64'(res_now));
            check("tag_out", 64'(bus.tag_out), 64'(tag_now));
            if (bus.flush) begin
                pend_valid = 1'b0;
                idle_from  = cyc + 1;
            end else if (bus.start && !pend_valid && cyc >= idle_from) begin
                pend_valid = 1'b1;
                acc_cyc    = cyc;
                done_cyc   = cyc + ref_lat(bus.funct3, bus.op_a, bus.op_b);
                pend_res   = ref_op(bus.funct3, bus.op_a, bus.op_b);
                pend_tag   = bus.tag_in;
                idle_from  = done_cyc + 1;
            end
        end
    end

    // Issue one op at the current cycle and check latency, result and tag directly
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        int n, lat;
        logic [4:0] t;
        t = 5'($urandom);
        bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.tag_in = t; bus.start = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done) begin lat = cyc - n; break; end
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_result"}, 64'(bus.result), 64'(exp_res));
        check({nm, "_tag"}, 64'(bus.tag_out), 64'(t));
        @(posedge clk); #1;
    endtask

    task automatic run_op8(input string nm, input logic [2:0] f3, input logic [7:0] a,
                           input logic [7:0] b, input int exp_lat, input logic [7:0] exp_res);
        int n, lat;
        bus8.funct3 = f3; bus8.op_a = a; bus8.op_b = b; bus8.tag_in = 5'd9; bus8.start = 1'b1;
        n = cyc;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus8.done) begin lat = cyc - n; break; end
        end
        check({nm, "_latency"}, 64'(lat), 64'(exp_lat));
        check({nm, "_result"}, 64'(bus8.result), 64'(exp_res));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int ndone, n;
        bus.start = 0; bus.flush = 0; bus.funct3 = 0; bus.op_a = 0; bus.op_b = 0; bus.tag_in = 0;
        bus8.start = 0; bus8.flush = 0; bus8.funct3 = 0; bus8.op_a = 0; bus8.op_b = 0; bus8.tag_in = 0;

        // Pin the reference model to hand-computed values
        check("model_mul",    64'(ref_op(MDU_MUL, 32'd7, 32'hFFFF_FFFD)), 64'hFFFF_FFEB);
        check("model_mulh",   64'(ref_op(MDU_MULH, 32'h8000_0000, 32'h8000_0000)), 64'h4000_0000);
        check("model_mulhu",  64'(ref_op(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE);
        check("model_mulhsu", 64'(ref_op(MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFF);
        check("model_div",    64'(ref_op(MDU_DIV, -32'd7, 32'd2)), 64'hFFFF_FFFD);
        check("model_rem",    64'(ref_op(MDU_REM, -32'd7, 32'd2)), 64'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul",     MDU_MUL,    32'd7,          32'hFFFF_FFFD, 34, 32'hFFFF_FFEB);
        run_op("mulh",    MDU_MULH,   32'h8000_0000,  32'h8000_0000, 34, 32'h4000_0000);
        run_op("mulhu",   MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
        run_op("mulhsu",  MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 34, 32'hFFFF_FFFF);
        run_op("div_neg", MDU_DIV,    -32'd7,         32'd2,         34, 32'hFFFF_FFFD);
        run_op("rem_neg", MDU_REM,    -32'd7,         32'd2,         34, 32'hFFFF_FFFF);
        run_op("divu0",   MDU_DIVU,   32'd5,          32'd0,         1,  32'hFFFF_FFFF);
        run_op("rem0",    MDU_REM,    32'd5,          32'd0,         1,  32'd5);
        run_op("div_ovf", MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1,  32'h8000_0000);
        run_op("rem_ovf", MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1,  32'd0);
        run_op("divu",    MDU_DIVU,   32'd100,        32'd7,         34, 32'd14);
        run_op("remu",    MDU_REMU,   32'd100,        32'd7,         34, 32'd2);

        // Flush in cycle n+10: idle from n+11, no done, result stays 2
        bus.funct3 = MDU_MUL; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin @(negedge clk); if (bus.done) ndone++; end
        check("flush_no_done", 64'(ndone), 64'd0);
        check("flush_result_kept", 64'(bus.result), 64'd2);
        @(posedge clk); #1;

        // Start pulsed while busy is ignored: exactly one done, first op's result
        bus.funct3 = MDU_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 begin bus.funct3 = MDU_MUL; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.start = 1'b1; end
        @(posedge clk); #1 bus.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 45; k++) begin @(negedge clk); if (bus.done) ndone++; end
        check("busy_start_single_done", 64'(ndone), 64'd1);
        check("busy_start_result", 64'(bus.result), 64'd14);
        @(posedge clk); #1;

        // Asynchronous reset mid-CALC clears outputs without a clock edge
        bus.funct3 = MDU_MULHU; bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF; bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_done", 64'(bus.done), 64'd0);
        check("async_rst_result", 64'(bus.result), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // XLEN=8 instance
        run_op8("x8_div_ovf", MDU_DIV,   8'h80, 8'hFF, 1,  8'h80);
        run_op8("x8_mulhu",   MDU_MULHU, 8'hFF, 8'hFF, 10, 8'hFE);

        // Randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.flush  = ($urandom_range(0, 199) == 0);
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.op_a   = pick();
            bus.op_b   = pick();
            bus.tag_in = 5'($urandom);
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.flush = 1'b0;
        n = cyc;
        while (pend_valid && cyc < n + 50) @(posedge clk);
        check("drain_idle", 64'(pend_valid), 64'd0);
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
